softmax_norm_ctrl: RTL and testbench
====================================

// Module: softmax_norm_ctrl
// PURPOSE
//  Issuer side of the team's multi-cycle fixed-point divider handshake for softmax normalisation.
//  - Collects one attention row of exp() values.
//  - Accumulates the row sum.
//  - Drives one divide per element (element / sum) through the divider start/valid interface.
//  - Streams the normalised quotients out with backpressure.
//  - Sits between the exp LUT stage and the attention-weight buffer in the MHA datapath.
// PARAMETERS
//  D_W       16  data width, signed two's complement
//  FRAC_BIT  13  fraction bits of input and quotient
//  ROW_LEN    8  elements per row (>=2)
//  DIV_TMO   15  max cycles from O_DIV_START rise to I_DIV_VLD before error
// PORTS
//  I_CLK        in   1        clock
//  I_RST_N      in   1        asynchronous active-low reset
//  I_IN_VLD     in   1        input element valid
//  O_IN_RDY     out  1        input element ready
//  I_IN_DATA    in   D_W      exp value; >=0 expected, negative treated as 0
//  O_DIV_START  out  1        divider start; held high for the whole divide
//  O_DIVIDEND   out  D_W      current element
//  O_DIVISOR    out  D_W      saturated row sum
//  I_QUOTIENT   in   D_W      divider result; sampled only when I_DIV_VLD=1
//  I_DIV_VLD    in   1        one-cycle divider done pulse
//  O_OUT_VLD    out  1        normalised element valid
//  I_OUT_RDY    in   1        downstream ready
//  O_OUT_DATA   out  D_W      normalised element
//  O_OUT_LAST   out  1        high with the ROW_LEN-th output
//  O_ERR        out  1        sticky divider timeout; cleared only by reset
// BEHAVIOUR
//  Reset values:
//  - All outputs 0, except O_IN_RDY=0 until the first cycle in S_IDLE.
//  - sum=0, indices=0, state S_IDLE.
//  Input accept: I_IN_VLD & O_IN_RDY on a rising edge.
//  Output accept: O_OUT_VLD & I_OUT_RDY on a rising edge.
//  S_IDLE
//  - O_IN_RDY=1.
//  - First accept: store element, sum <= element, go to S_LOAD.
//  S_LOAD
//  - O_IN_RDY=1.
//  - Each accept: store element at wr_idx, sum += element.
//  - Accepting element ROW_LEN-1 (0-based) -> S_CHK, O_IN_RDY=0.
//  S_CHK (one cycle)
//  - Divisor = sum saturated to 2^(D_W-1)-1.
//  - sum==0 -> S_OUT with O_OUT_DATA=0 for every element; no divides are issued.
//  - else -> S_ISSUE.
//  S_ISSUE (one cycle)
//  - Drive O_DIVIDEND=buf[rd_idx] and O_DIVISOR.
//  - Raise O_DIV_START, clear the timeout counter, go to S_WAIT.
//  S_WAIT
//  - O_DIV_START held 1; O_DIVIDEND and O_DIVISOR stable.
//  - I_DIV_VLD=1: capture I_QUOTIENT; O_DIV_START drops at the same edge; go to S_OUT.
//  - Counter reaches DIV_TMO: set O_ERR, output 0 for this element, go to S_OUT.
//  - Nominal latency is 4 cycles from O_DIV_START rise to I_DIV_VLD.
//  S_OUT
//  - O_OUT_VLD=1 and O_OUT_DATA are held until accepted.
//  - O_OUT_LAST=1 when rd_idx==ROW_LEN-1.
//  - On accept: rd_idx++. Last element -> S_IDLE. Else -> S_ISSUE (divide path) or stay in S_OUT (zero path).
//  Divider spacing:
//  - O_DIV_START is low for at least one cycle between divides (S_OUT + S_ISSUE give >=2).
//  - This lets the divider pass through its post-result state.
//  Arithmetic:
//  - sum register is D_W+$clog2(ROW_LEN) bits, unsigned.
//  - Negative inputs clamp to 0 before storage.
//  - The quotient passes through unmodified.
//  Boundary conditions:
//  - No input accepted outside S_IDLE/S_LOAD; a new row may start only after O_OUT_LAST is accepted.
//  - I_DIV_VLD outside S_WAIT is ignored.
//  - Reset mid-operation returns to S_IDLE and drops O_DIV_START immediately (asynchronous).
//  - I_OUT_RDY low for any duration stalls S_OUT with no data loss.
// STRUCTURE
//  Package softmax_norm_pkg:
//  - state enum {S_IDLE,S_LOAD,S_CHK,S_ISSUE,S_WAIT,S_OUT} (3 bits).
//  - SUM_W localparam function.
//  - Saturation helper function.
//  Sub-module sm_row_buf:
//  - ROW_LEN x D_W register file, one write and one read port, clamp-on-write.
//  Top holds the FSM, the sum accumulator, the timeout counter and the divider-interface registers.
// TESTING
//  Bench has a divider model with a 4-cycle start->valid pulse and a true quotient; it checks that O_DIV_START is held and that one gap cycle separates divides.
//  1. Row of 8 x 0x0400 (0.125), I_OUT_RDY=1 -> sum 0x2000; 8 divides; each O_OUT_DATA = model(0x0400/0x2000); LAST on the 8th.
//  2. Row {0x2000,0,0,0,0,0,0,0} -> O_DIVISOR=0x2000; outputs {model(0x2000/0x2000), then 0 x7}.
//  3. All-zero row -> O_DIV_START never rises; 8 outputs of 0; LAST on the 8th.
//  4. 8 x 0x7000 -> sum overflows; O_DIVISOR=0x7FFF; O_DIVIDEND=0x7000 on every divide.
//  5. Model never pulses valid -> O_ERR=1 at cycle 15 of S_WAIT; output 0; O_ERR stays 1 through later rows.
//  6. I_OUT_RDY low 10 cycles mid-row, then an async reset during S_WAIT -> data held stable while stalled; after reset O_DIV_START=0, O_IN_RDY=1 and the next row is correct.

Source files
------------

// File: rtl/softmax_norm_pkg.sv
// Shared types, widths and helpers for the softmax normalisation controller.
package softmax_norm_pkg;

  localparam int unsigned D_W     = 16;
  localparam int unsigned ROW_LEN = 8;
  localparam int unsigned DIV_TMO = 15;
  localparam int unsigned IDX_W   = $clog2(ROW_LEN);
  localparam int unsigned TMO_W   = $clog2(DIV_TMO + 1);

  // Row sum needs log2(ROW_LEN) guard bits above the element width.
  function automatic int unsigned sum_width(input int unsigned dw, input int unsigned n);
    return dw + $clog2(n);
  endfunction

  localparam int unsigned SUM_W = sum_width(D_W, ROW_LEN);

  localparam logic [D_W-1:0] SAT_MAX = {1'b0, {(D_W-1){1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHK   = 3'd2,
    S_ISSUE = 3'd3,
    S_WAIT  = 3'd4,
    S_OUT   = 3'd5
  } state_e;

  // Saturate the unsigned row sum to the largest positive D_W value.
  function automatic logic [D_W-1:0] sat_sum(input logic [SUM_W-1:0] s);
    if (|s[SUM_W-1:D_W-1]) return SAT_MAX;
    return s[D_W-1:0];
  endfunction

endpackage

// File: rtl/sm_row_buf.sv
// Row buffer: ROW_LEN x D_W register file, negative inputs clamped to 0 on write.
// Ports: clk/rst_n; we, wr_idx, wr_data write port; wr_clamp_c clamped write value;
//        rd_idx, rd_data_c combinational read port.
module sm_row_buf
  import softmax_norm_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [D_W-1:0]   wr_data,
  output logic [D_W-1:0]   wr_clamp_c,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [D_W-1:0]   rd_data_c
);

  logic [D_W-1:0] mem [ROW_LEN];

  assign wr_clamp_c = wr_data[D_W-1] ? '0 : wr_data;
  assign rd_data_c  = mem[rd_idx];

  // Storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(ROW_LEN); i++) mem[i] <= '0;
    end else if (we) begin
      mem[wr_idx] <= wr_clamp_c;
    end
  end

endmodule

// File: rtl/softmax_norm_ctrl.sv
// Softmax row normaliser: collects a row of exp() values, sums them, issues one
// divide per element over the start/valid divider handshake and streams the
// quotients out with backpressure. A zero-sum row skips the divider and emits zeros.
// Ports: clk, rst_n; in_vld/in_rdy/in_data element input; div_start, dividend,
//        divisor, quotient, div_vld divider interface; out_vld/out_rdy/out_data/
//        out_last result stream; err sticky divider timeout.
module softmax_norm_ctrl
  import softmax_norm_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_vld,
  output logic           in_rdy,
  input  logic [D_W-1:0] in_data,
  output logic           div_start,
  output logic [D_W-1:0] dividend,
  output logic [D_W-1:0] divisor,
  input  logic [D_W-1:0] quotient,
  input  logic           div_vld,
  output logic           out_vld,
  input  logic           out_rdy,
  output logic [D_W-1:0] out_data,
  output logic           out_last,
  output logic           err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROW_LEN - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DIV_TMO - 1);

  state_e           state_q, state_nxt;
  logic [SUM_W-1:0] sum_q, sum_nxt;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_nxt, rd_idx_q, rd_idx_nxt;
  logic [TMO_W-1:0] tmo_q, tmo_nxt;
  logic             zero_q, zero_nxt;
  logic             in_rdy_nxt, div_start_nxt, out_vld_nxt, out_last_nxt, err_nxt;
  logic [D_W-1:0]   dividend_nxt, divisor_nxt, out_data_nxt;
  logic             buf_we_c, in_acc_c, out_acc_c;
  logic [D_W-1:0]   wr_clamp_c, rd_data_c;

  sm_row_buf u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .we         (buf_we_c),
    .wr_idx     (wr_idx_q),
    .wr_data    (in_data),
    .wr_clamp_c (wr_clamp_c),
    .rd_idx     (rd_idx_q),
    .rd_data_c  (rd_data_c)
  );

  assign in_acc_c  = in_vld & in_rdy;
  assign out_acc_c = out_vld & out_rdy;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      sum_q     <= '0;
      wr_idx_q  <= '0;
      rd_idx_q  <= '0;
      tmo_q     <= '0;
      zero_q    <= 1'b0;
      in_rdy    <= 1'b0;
      div_start <= 1'b0;
      dividend  <= '0;
      divisor   <= '0;
      out_vld   <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      sum_q     <= sum_nxt;
      wr_idx_q  <= wr_idx_nxt;
      rd_idx_q  <= rd_idx_nxt;
      tmo_q     <= tmo_nxt;
      zero_q    <= zero_nxt;
      in_rdy    <= in_rdy_nxt;
      div_start <= div_start_nxt;
      dividend  <= dividend_nxt;
      divisor   <= divisor_nxt;
      out_vld   <= out_vld_nxt;
      out_data  <= out_data_nxt;
      out_last  <= out_last_nxt;
      err       <= err_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt    = state_q;
    sum_nxt      = sum_q;
    wr_idx_nxt   = wr_idx_q;
    rd_idx_nxt   = rd_idx_q;
    tmo_nxt      = tmo_q;
    zero_nxt     = zero_q;
    dividend_nxt = dividend;
    divisor_nxt  = divisor;
    out_data_nxt = out_data;
    err_nxt      = err;
    buf_we_c     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (in_acc_c) begin
          buf_we_c   = 1'b1;
          sum_nxt    = SUM_W'(wr_clamp_c);
          wr_idx_nxt = IDX_W'(1);
          state_nxt  = S_LOAD;
        end
      end
      S_LOAD: begin
        if (in_acc_c) begin
          buf_we_c = 1'b1;
          sum_nxt  = sum_q + SUM_W'(wr_clamp_c);
          if (wr_idx_q == LAST_IDX) begin
            wr_idx_nxt = '0;
            state_nxt  = S_CHK;
          end else begin
            wr_idx_nxt = wr_idx_q + IDX_W'(1);
          end
        end
      end
      S_CHK: begin
        divisor_nxt = sat_sum(sum_q);
        rd_idx_nxt  = '0;
        zero_nxt    = (sum_q == '0);
        if (sum_q == '0) begin
          out_data_nxt = '0;
          state_nxt    = S_OUT;
        end else begin
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        dividend_nxt = rd_data_c;
        tmo_nxt      = '0;
        state_nxt    = S_WAIT;
      end
      S_WAIT: begin
        // A result arriving on the last allowed cycle still wins over the timeout.
        if (div_vld) begin
          out_data_nxt = quotient;
          state_nxt    = S_OUT;
        end else if (tmo_q == TMO_LAST) begin
          err_nxt      = 1'b1;
          out_data_nxt = '0;
          state_nxt    = S_OUT;
        end else begin
          tmo_nxt = tmo_q + TMO_W'(1);
        end
      end
      S_OUT: begin
        if (out_acc_c) begin
          if (rd_idx_q == LAST_IDX) begin
            rd_idx_nxt = '0;
            state_nxt  = S_IDLE;
          end else begin
            rd_idx_nxt = rd_idx_q + IDX_W'(1);
            state_nxt  = zero_q ? S_OUT : S_ISSUE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // Handshake outputs are registered copies of the next state.
    in_rdy_nxt    = (state_nxt == S_IDLE) || (state_nxt == S_LOAD);
    div_start_nxt = (state_nxt == S_WAIT);
    out_vld_nxt   = (state_nxt == S_OUT);
    out_last_nxt  = (state_nxt == S_OUT) && (rd_idx_nxt == LAST_IDX);
  end

endmodule

// File: tb/tb_softmax_norm_ctrl.sv
// Self-checking bench for softmax_norm_ctrl with a 4-cycle divider model and
// an output scoreboard.
`timescale 1ns/1ps
module tb_softmax_norm_ctrl;
  import softmax_norm_pkg::*;

  localparam int N    = int'(ROW_LEN);
  localparam int FRAC = 13;

  typedef struct packed {
    logic [N-1:0][D_W-1:0] elem;
    logic [D_W-1:0]        exp_divisor;
    logic [7:0]            exp_ndiv;
    logic                  hang;
    logic                  exp_err;
  } vec_t;

  typedef struct packed {
    logic [D_W-1:0] data;
    logic           last;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_vld, in_rdy;
  logic [D_W-1:0] in_data;
  logic           div_start, div_vld;
  logic [D_W-1:0] dividend, divisor, quotient;
  logic           out_vld, out_rdy, out_last, err;
  logic [D_W-1:0] out_data;

  int             n_chk  = 0;
  int             n_fail = 0;
  int             n_rises = 0;
  bit             hang = 1'b0;
  bit             rdy_hold = 1'b0;
  int             spur_req = 0;
  logic [D_W-1:0] cur_exp_div = '0;
  exp_t           sb[$];
  logic [31:0]    div_q[$];
  vec_t           tbl[7];

  softmax_norm_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data),
    .div_start(div_start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .div_vld(div_vld),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data), .out_last(out_last),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // True fixed-point quotient, saturated to the positive range.
  function automatic logic [D_W-1:0] qfun(input longint a, input longint b);
    longint q;
    if (b == 0) return '0;
    q = (a <<< FRAC) / b;
    return (q > 32767) ? 16'h7FFF : 16'(q);
  endfunction

  // Divider model: valid pulse on the 4th cycle of start; also audits the handshake.
  initial begin
    int cnt = 0;
    bit start_prev = 1'b0, vld_prev = 1'b0;
    int spur_done = 0;
    logic [D_W-1:0] dd = '0, dv = '0;
    logic [31:0] e;
    div_vld = 1'b0;
    quotient = '0;
    forever begin
      @(negedge clk);
      div_vld = 1'b0;
      if (!rst_n) begin
        cnt = 0; start_prev = 1'b0; vld_prev = 1'b0;
      end else begin
        if (vld_prev) check("start_drop_after_vld", 64'(div_start), 0);
        if (div_start) begin
          if (!start_prev) begin
            n_rises++;
            dd = dividend; dv = divisor;
            check("divisor_const", 64'(divisor), 64'(cur_exp_div));
            if (div_q.size() == 0) begin
              check("unexpected_divide", 1, 0);
            end else begin
              e = div_q.pop_front();
              check("dividend", 64'(dividend), 64'(e[31:16]));
              check("divisor", 64'(divisor), 64'(e[15:0]));
            end
          end else if (!vld_prev) begin
            check("dividend_stable", 64'(dividend), 64'(dd));
            check("divisor_stable", 64'(divisor), 64'(dv));
          end
          cnt++;
          if (cnt == 4 && !hang) begin
            div_vld = 1'b1;
            quotient = qfun(64'(dividend), 64'(divisor));
          end
        end else begin
          if (start_prev && !vld_prev) begin
            check("start_held_until_tmo", 64'(hang), 1);
            check("tmo_cycle", 64'(cnt), 64'(DIV_TMO));
            check("err_on_tmo", 64'(err), 1);
          end
          cnt = 0;
          if (spur_req != spur_done) begin
            spur_done = spur_req;
            div_vld = 1'b1;
            quotient = 16'h1234;
          end
        end
        vld_prev = div_vld;
        start_prev = div_start;
      end
    end
  end

  // Output consumer with random backpressure; compares against the scoreboard.
  initial begin
    exp_t x;
    out_rdy = 1'b0;
    forever begin
      @(negedge clk);
      out_rdy = !rdy_hold && ($urandom_range(3) != 0);
      if (rst_n && out_vld && out_rdy) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          x = sb.pop_front();
          check("out_data", 64'(out_data), 64'(x.data));
          check("out_last", 64'(out_last), 64'(x.last));
        end
      end
    end
  end

  // Push expectations for a row, then drive its elements.
  task automatic send_row(input vec_t v);
    longint sum = 0;
    longint dv;
    logic [D_W-1:0] c;
    exp_t x;
    int t;
    for (int i = 0; i < N; i++) sum += v.elem[i][D_W-1] ? 0 : longint'(v.elem[i]);
    dv = (sum > 32767) ? 32767 : sum;
    for (int i = 0; i < N; i++) begin
      c = v.elem[i][D_W-1] ? '0 : v.elem[i];
      if (sum != 0) div_q.push_back({c, 16'(dv)});
      x.data = (sum == 0 || v.hang) ? '0 : qfun(64'(c), dv);
      x.last = (i == N - 1);
      sb.push_back(x);
    end
    for (int i = 0; i < N; i++) begin
      in_vld = 1'b1;
      in_data = v.elem[i];
      t = 0;
      while (!in_rdy && t < 500) begin @(negedge clk); t++; end
      if (!in_rdy) begin
        check("in_rdy_timeout", 0, 1);
        break;
      end
      @(negedge clk);
    end
    in_vld = 1'b0;
    in_data = '0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (sb.size() != 0 && t < 3000) begin @(negedge clk); t++; end
    check("drain_timeout", 64'(sb.size()), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    vec_t v;
    logic [D_W-1:0] snap;
    logic snap_last;
    int r0, t;

    tbl[0] = '{elem: {N{16'h0400}}, exp_divisor: 16'h2000, exp_ndiv: 8'd8, hang: 1'b0, exp_err: 1'b0};
    tbl[1] = '{elem: '0, exp_divisor: 16'h2000, exp_ndiv: 8'd8, hang: 1'b0, exp_err: 1'b0};
    tbl[1].elem[0] = 16'h2000;
    tbl[2] = '{elem: '0, exp_divisor: 16'h0000, exp_ndiv: 8'd0, hang: 1'b0, exp_err: 1'b0};
    tbl[3] = '{elem: {N{16'h7000}}, exp_divisor: 16'h7FFF, exp_ndiv: 8'd8, hang: 1'b0, exp_err: 1'b0};
    tbl[4] = '{elem: {N{16'h1000}}, exp_divisor: 16'h7000, exp_ndiv: 8'd8, hang: 1'b0, exp_err: 1'b0};
    tbl[4].elem[0] = 16'hF000;
    tbl[5] = '{elem: {N{16'h0400}}, exp_divisor: 16'h2000, exp_ndiv: 8'd8, hang: 1'b1, exp_err: 1'b1};
    tbl[6] = '{elem: {N{16'h0400}}, exp_divisor: 16'h2000, exp_ndiv: 8'd8, hang: 1'b0, exp_err: 1'b1};

    rst_n = 1'b0;
    in_vld = 1'b0;
    in_data = '0;
    repeat (2) @(negedge clk);
    check("rst_in_rdy", 64'(in_rdy), 0);
    check("rst_div_start", 64'(div_start), 0);
    check("rst_out_vld", 64'(out_vld), 0);
    check("rst_out_data", 64'(out_data), 0);
    check("rst_out_last", 64'(out_last), 0);
    check("rst_err", 64'(err), 0);
    check("rst_dividend", 64'(dividend), 0);
    check("rst_divisor", 64'(divisor), 0);
    #2 rst_n = 1'b1;
    #1 check("in_rdy_before_idle", 64'(in_rdy), 0);
    @(negedge clk);
    check("in_rdy_idle", 64'(in_rdy), 1);

    for (int r = 0; r < 7; r++) begin
      hang = tbl[r].hang;
      cur_exp_div = tbl[r].exp_divisor;
      r0 = n_rises;
      send_row(tbl[r]);
      wait_drain();
      check($sformatf("row%0d_ndiv", r), 64'(n_rises - r0), 64'(tbl[r].exp_ndiv));
      check($sformatf("row%0d_err", r), 64'(err), 64'(tbl[r].exp_err));
      check($sformatf("row%0d_divq_empty", r), 64'(div_q.size()), 0);
    end
    hang = 1'b0;

    // Stall mid-row with a stray divider pulse, then reset during a divide.
    for (int i = 0; i < N; i++) v.elem[i] = 16'(16'h0100 * (i + 1));
    v.exp_divisor = 16'h2400; v.exp_ndiv = 8'd8; v.hang = 1'b0; v.exp_err = 1'b0;
    cur_exp_div = 16'h2400;
    rdy_hold = 1'b1;
    send_row(v);
    t = 0;
    while (!out_vld && t < 100) begin @(negedge clk); t++; end
    check("stall_out_vld", 64'(out_vld), 1);
    snap = out_data;
    snap_last = out_last;
    check("stall_first_data", 64'(snap), 64'(qfun(64'h0100, 64'h2400)));
    for (int k = 0; k < 10; k++) begin
      if (k == 3) spur_req++;
      @(negedge clk);
      check("stall_vld_held", 64'(out_vld), 1);
      check("stall_data_held", 64'(out_data), 64'(snap));
      check("stall_last_held", 64'(out_last), 64'(snap_last));
    end
    rdy_hold = 1'b0;
    t = 0;
    while (!div_start && t < 100) begin @(negedge clk); t++; end
    check("second_divide_start", 64'(div_start), 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_div_start", 64'(div_start), 0);
    check("async_rst_out_vld", 64'(out_vld), 0);
    check("async_rst_in_rdy", 64'(in_rdy), 0);
    check("async_rst_err", 64'(err), 0);
    sb.delete();
    div_q.delete();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_rdy", 64'(in_rdy), 1);
    check("post_rst_div_start", 64'(div_start), 0);

    cur_exp_div = tbl[4].exp_divisor;
    r0 = n_rises;
    send_row(tbl[4]);
    wait_drain();
    check("post_rst_ndiv", 64'(n_rises - r0), 8);
    check("post_rst_err", 64'(err), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
